// File: rtl/hvl_pkg.sv
// hvl_pkg: phase encoding, bus widths and core flag bit positions for the Hovalaag I/O sequencer
package hvl_pkg;
    localparam int WORD_W = 12;
    localparam int INSTR_W = 32;
    localparam int CONSUME_BIT = 1;
    localparam int STROBE_BIT = 0;
    typedef enum logic [2:0] {IDLE, P0, P1, P2, P3} phase_t;
endpackage

// File: rtl/hvl_sync_fifo.sv
// hvl_sync_fifo: single-clock FIFO whose head reads as zero when empty; a push into a full FIFO lands if a pop happens that cycle
module hvl_sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push && !rst)
            mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/hvl_io_sequencer.sv
// hvl_io_sequencer: streams instruction words and IN values onto the core bus in a 4-phase slot and buffers OUT values
module hvl_io_sequencer
    import hvl_pkg::*;
#(
    parameter int IN_DEPTH = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_data,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               core_ena,
    output logic [WORD_W-1:0]  core_din,
    input  logic [WORD_W-1:0]  core_dout,
    input  logic               clr_sticky,
    output logic               busy,
    output logic               in_underflow,
    output logic               out_overflow
);
    phase_t state, state_d;
    logic [INSTR_W-1:WORD_W] instr_q;
    logic consume_q, strobe_q;
    logic [WORD_W-1:0] din_d, in_head;
    logic in_full, in_empty, out_full, out_empty;
    logic [$clog2(IN_DEPTH):0] in_count;
    logic [$clog2(OUT_DEPTH):0] out_count;
    logic accept, in_push, in_pop, out_push, out_pop, slot, underflow_set, overflow_set;
    assign instr_ready = !rst && (state == IDLE || state == P3);
    assign accept = instr_valid && instr_ready;
    assign in_ready = !rst && !in_full;
    assign in_push = in_valid && in_ready;
    assign out_valid = out_count != '0;
    assign out_pop = out_ready && !out_empty;
    assign slot = state == P3;
    assign in_pop = slot && consume_q && !in_empty;
    assign underflow_set = slot && consume_q && in_empty;
    assign out_push = slot && strobe_q;
    assign overflow_set = out_push && out_full && !out_pop;
    assign busy = core_ena;
    always_comb begin
        state_d = state;
        din_d = '0;
        case (state)
            IDLE, P3: state_d = accept ? P0 : IDLE;
            P0:       state_d = P1;
            P1:       state_d = P2;
            P2:       state_d = P3;
            default:  state_d = IDLE;
        endcase
        // core_din is registered, so the P3 value must see an IN word arriving during P2
        case (state_d)
            P0:      din_d = instr_data[WORD_W-1:0];
            P1:      din_d = instr_q[2*WORD_W-1:WORD_W];
            P2:      din_d = WORD_W'(instr_q[INSTR_W-1:2*WORD_W]);
            P3:      din_d = (in_count == '0 && in_push) ? in_data : in_head;
            default: din_d = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            instr_q <= '0;
            consume_q <= 1'b0;
            strobe_q <= 1'b0;
            core_ena <= 1'b0;
            core_din <= '0;
            in_underflow <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            state <= state_d;
            core_ena <= state_d != IDLE;
            core_din <= din_d;
            instr_q <= accept ? instr_data[INSTR_W-1:WORD_W] : instr_q;
            consume_q <= (state == P2) ? core_dout[CONSUME_BIT] : consume_q;
            strobe_q <= (state == P2) ? core_dout[STROBE_BIT] : strobe_q;
            in_underflow <= underflow_set || (in_underflow && !clr_sticky);
            out_overflow <= overflow_set || (out_overflow && !clr_sticky);
        end
    end
    hvl_sync_fifo #(.WIDTH(WORD_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk(clk),
        .rst(rst),
        .push(in_push),
        .pop(in_pop),
        .din(in_data),
        .head(in_head),
        .full(in_full),
        .empty(in_empty),
        .count(in_count)
    );
    hvl_sync_fifo #(.WIDTH(WORD_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk(clk),
        .rst(rst),
        .push(out_push),
        .pop(out_pop),
        .din(core_dout),
        .head(out_data),
        .full(out_full),
        .empty(out_empty),
        .count(out_count)
    );
endmodule
